// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb: VRAM port arbiter for the PPU.
// Fixed priority background > sprite > CPU, decided combinationally each cycle.
// CPU (PPUDATA) accesses are queued as a single latched request and run through
// an IDLE -> PEND -> ACC sequence, completing with a one-cycle done pulse.
// Optional feature macro: PPU_VRAM_ARB_STARVE_EN forces a CPU grant after the
// request has waited STARVE_LIMIT cycles in PEND.
module ppu_vram_arb #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        bg_req_in,
    input  logic [13:0] bg_a_in,
    input  logic        spr_req_in,
    input  logic [13:0] spr_a_in,
    input  logic        cpu_req_in,
    input  logic [13:0] cpu_a_in,
    input  logic        cpu_wr_in,
    input  logic [7:0]  cpu_d_in,
    input  logic [7:0]  vram_d_in,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_we_out,
    output logic        bg_gnt_out,
    output logic        spr_gnt_out,
    output logic        cpu_busy_out,
    output logic        cpu_done_out,
    output logic [7:0]  cpu_rd_d_out
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACC} state_t;

    state_t      state, state_nxt;
    logic [13:0] lat_a;
    logic        lat_wr;
    logic [7:0]  lat_d;
    logic [13:0] last_a;
    logic        force_cpu;
    logic        cpu_gnt;

`ifdef PPU_VRAM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    // Count PEND cycles without a grant; cleared whenever PEND is left.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                          starve_cnt <= '0;
        else if (state == S_PEND && !cpu_gnt) starve_cnt <= starve_cnt + CW'(1);
        else                                  starve_cnt <= '0;
    end

    assign force_cpu = (state == S_PEND) && (starve_cnt == CW'(STARVE_LIMIT));
`else
    assign force_cpu = 1'b0;
`endif

    // Grants and VRAM port mux; rst_in gating keeps the port quiet during reset
    // even if a renderer is requesting.
    always_comb begin
        bg_gnt_out  = rst_in && bg_req_in && !force_cpu;
        spr_gnt_out = rst_in && spr_req_in && !bg_req_in && !force_cpu;
        cpu_gnt     = rst_in && (state == S_PEND) &&
                      (force_cpu || (!bg_req_in && !spr_req_in));
        if (bg_gnt_out)       vram_a_out = bg_a_in;
        else if (spr_gnt_out) vram_a_out = spr_a_in;
        else if (cpu_gnt)     vram_a_out = lat_a;
        else                  vram_a_out = last_a;
        vram_we_out = cpu_gnt && lat_wr;
        vram_d_out  = cpu_gnt ? lat_d : 8'h00;
    end

    // Remember the last driven address so an idle port holds it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) last_a <= '0;
        else         last_a <= vram_a_out;
    end

    // CPU FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // CPU FSM next state and status outputs.
    always_comb begin
        state_nxt    = state;
        cpu_busy_out = (state != S_IDLE);
        cpu_done_out = (state == S_ACC);
        case (state)
            S_IDLE:  if (cpu_req_in) state_nxt = S_PEND;
            S_PEND:  if (cpu_gnt)    state_nxt = S_ACC;
            S_ACC:                   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Latch the CPU request only when accepted from IDLE; later pulses are ignored.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lat_a  <= '0;
            lat_wr <= 1'b0;
            lat_d  <= '0;
        end else if (state == S_IDLE && cpu_req_in) begin
            lat_a  <= cpu_a_in;
            lat_wr <= cpu_wr_in;
            lat_d  <= cpu_d_in;
        end
    end

    // Capture read data at the end of the CPU grant cycle; writes leave it alone.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                cpu_rd_d_out <= '0;
        else if (cpu_gnt && !lat_wr) cpu_rd_d_out <= vram_d_in;
    end

endmodule

// File: doc/ppu_vram_arb.md
PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 64, meaning CPU wait cycles before a forced grant (used only with PPU_VRAM_ARB_STARVE_EN).
REQ-002 SHALL have port clk_in  input  1  100MHz system clock, rising-edge active.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bg_req_in  input  1  background fetch wants VRAM this cycle.
REQ-005 SHALL have port bg_a_in  input  14  background fetch address.
REQ-006 SHALL have port spr_req_in  input  1  sprite fetch wants VRAM this cycle.
REQ-007 SHALL have port spr_a_in  input  14  sprite fetch address.
REQ-008 SHALL have port cpu_req_in  input  1  one-cycle pulse requesting a CPU (PPUDATA) access.
REQ-009 SHALL have port cpu_a_in  input  14  CPU access address, sampled with cpu_req_in.
REQ-010 SHALL have port cpu_wr_in  input  1  1 = write, 0 = read, sampled with cpu_req_in.
REQ-011 SHALL have port cpu_d_in  input  8  CPU write data, sampled with cpu_req_in.
REQ-012 SHALL have port vram_d_in  input  8  VRAM read data, valid in the same cycle as vram_a_out.
REQ-013 SHALL have port vram_a_out  output  14  VRAM address.
REQ-014 SHALL have port vram_d_out  output  8  VRAM write data.
REQ-015 SHALL have port vram_we_out  output  1  VRAM write strobe.
REQ-016 SHALL have port bg_gnt_out / spr_gnt_out  output  1 each  combinational grant for the current cycle.
REQ-017 SHALL have port cpu_busy_out  output  1  CPU access pending or in progress.
REQ-018 SHALL have port cpu_done_out  output  1  one-cycle completion pulse.
REQ-019 SHALL have port cpu_rd_d_out  output  8  registered CPU read data.

Function
REQ-020 SHALL use fixed priority bg > spr > cpu, decided combinationally each cycle; exactly one grant or none.
REQ-021 SHALL drive vram_a_out from the granted requester; with no grant, it holds the last driven address and vram_we_out is 0.
REQ-022 SHALL implement CPU FSM states IDLE, PEND, ACC.
- IDLE -> PEND on cpu_req_in: latch address, wr and data; cpu_busy_out = 1 from the next cycle.
REQ-023 SHALL, in PEND, grant the CPU in any cycle where bg_req_in = 0 and spr_req_in = 0.
- In a CPU grant cycle: vram_a_out = latched address; vram_we_out = latched wr; vram_d_out = latched data.
- Next state is ACC.
REQ-024 SHALL, in ACC (one cycle after grant):
- pulse cpu_done_out;
- present cpu_rd_d_out holding the vram_d_in captured at the end of the grant cycle (reads only; writes leave it unchanged);
- return to IDLE with cpu_busy_out = 0.
REQ-025 SHALL give a minimum latency of request pulse at cycle N, grant at N+1, cpu_done_out at N+2.
REQ-026 SHALL ignore cpu_req_in while in PEND or ACC, leaving the latched request unchanged.
REQ-027 SHALL accept cpu_req_in in the IDLE cycle immediately after ACC (back-to-back accesses).
REQ-028 SHALL, when bg_req_in and spr_req_in are asserted together, grant bg only; the sprite requester gets no retry support from this block.

Reset
REQ-029 SHALL, while rst_in = 0, asynchronously force:
- FSM to IDLE;
- latched request, cpu_rd_d_out, vram_a_out and vram_d_out to 0;
- vram_we_out, cpu_busy_out and cpu_done_out to 0;
- starvation counter to 0.
REQ-030 SHALL abort a pending or in-progress CPU access on reset without any cpu_done_out pulse.
REQ-031 SHALL resume normal operation on the first rising clk_in edge after rst_in returns to 1.

Configuration
REQ-032 SHALL, with PPU_VRAM_ARB_STARVE_EN defined, count cycles in PEND.
- When the count reaches STARVE_LIMIT, the CPU is granted in the next cycle regardless of bg/spr requests.
- In that cycle bg_gnt_out = spr_gnt_out = 0.
- The counter clears on leaving PEND.
REQ-033 SHALL, without PPU_VRAM_ARB_STARVE_EN, contain no counter; PEND may last indefinitely.

Verification
REQ-034 SHALL cover CPU read while idle: cpu_req_in with a=0x2005 and vram_d_in=0x5A at grant -> vram_a_out=0x2005 at N+1, cpu_done_out at N+2, cpu_rd_d_out=0x5A.
REQ-035 SHALL cover CPU write under render: bg_req_in held for 10 cycles, CPU write 0x3F00/0x1C -> no grant until bg drops, then one cycle with vram_we_out=1, vram_a_out=0x3F00, vram_d_out=0x1C.
REQ-036 SHALL cover priority: bg_req_in=spr_req_in=1 with bg_a_in=0x23C0, spr_a_in=0x1010 -> bg_gnt_out=1, spr_gnt_out=0, vram_a_out=0x23C0.
REQ-037 SHALL cover a second cpu_req_in during PEND -> ignored; exactly one cpu_done_out, and the original address is used.
REQ-038 SHALL cover reset during PEND: rst_in low for 1 cycle -> cpu_busy_out=0 immediately, no cpu_done_out, vram_we_out=0.
REQ-039 SHALL cover starvation with PPU_VRAM_ARB_STARVE_EN and STARVE_LIMIT=64: bg_req_in held continuously -> CPU granted in the 65th PEND cycle, cpu_done_out one cycle later.
